multicycle_control_unit: RTL
============================

# multicycle_control_unit

Parametrised multicycle successor to the single-cycle MIPS control unit. It decodes the latched instruction word and sequences FETCH/DECODE/EXEC/MEM/WB through a state machine. It performs request/hit handshakes with the instruction and data memory ports and drives every datapath enable. It sits between the instruction register and the multicycle datapath, and adds sticky halt, illegal-opcode trapping and a configurable memory-wait timeout.

## Interface
- WORD_W, 32: instruction/word width; opcode fixed at [WORD_W-1:WORD_W-6], funct at [5:0].
- MEM_WAIT_MAX, 0: maximum wait cycles on ihit/dhit before trap; 0 disables the timeout.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous active-high reset.
- instr  in  WORD_W  current instruction register contents.
- ihit, dhit  in  1  memory port completion strobes.
- zero  in  1  ALU zero flag, valid in EXEC.
- iREN  out  1  instruction read request.
- dREN, dWEN  out  1  data read/write request.
- IRWEN, PCWEN  out  1  instruction register / PC write enables.
- PCSrc  out  2  00 PC+4, 01 branch target, 10 jump target, 11 rs (JR).
- RegDst  out  2  00 rt, 01 rd, 10 $31.
- MemtoReg  out  2  00 ALU, 01 memory data, 10 PC+4.
- ALUSrc  out  1  0 register, 1 extended immediate.
- ExtOp  out  2  00 zero-extend, 01 sign-extend, 10 LUI shift.
- ALUOp  out  aluop_t  ALU operation.
- RegWEN  out  1  register file write enable.
- halt  out  1  sticky halt.
- trap  out  2  00 none, 01 illegal opcode/funct, 10 memory timeout; sticky with halt.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: iREN=1. On ihit: IRWEN=1, PCWEN=1, PCSrc=00, next DECODE. Without ihit: stay.
- DECODE: opcode HALT goes to HALT. J: PCWEN, PCSrc=10, next FETCH. JAL: additionally RegWEN, RegDst=10, MemtoReg=10. Illegal opcode or R-type funct: trap=01, next HALT. All other instructions go to EXEC.
- EXEC: ALUOp/ALUSrc/ExtOp driven from decode.
  - BEQ: PCWEN=zero, PCSrc=01, next FETCH.
  - BNE: PCWEN=!zero, PCSrc=01, next FETCH.
  - JR: PCWEN, PCSrc=11, next FETCH.
  - LW/SW: next MEM.
  - All others: next WB.
- MEM: LW holds dREN=1; SW holds dWEN=1. On dhit: LW goes to WB, SW goes to FETCH. Never both requests at once.
- WB: RegWEN=1. RegDst is 01 for R-type and 00 for I-type. MemtoReg is 01 for LW and 00 otherwise. Next FETCH.
- HALT: halt=1; all enables and requests 0; exits only on RST.
- Timeout:
  - The wait counter clears on entry to FETCH/MEM and on any hit.
  - It increments each cycle a request is unanswered.
  - When it reaches MEM_WAIT_MAX (if nonzero) without a hit: trap=10, next HALT, request dropped that cycle.
  - Counter width is $clog2(MEM_WAIT_MAX+1), minimum 1.
- Decode mappings:
  - SLL/SRL take ALU_SLL/ALU_SRL.
  - ADD/ADDU/ADDI/ADDIU/LW/SW take ALU_ADD.
  - SUB/SUBU/BEQ/BNE take ALU_SUB.
  - Logical ops take their ALU_ counterpart; SLT/SLTI take ALU_SLT; SLTU/SLTIU take ALU_SLTU.
  - ANDI/ORI/XORI zero-extend; LUI uses ExtOp=10 with ALU_OR.
- Outputs are combinational from state, decoded instr and hit/zero inputs. State, counter, halt and trap are registered.

## Timing
- While RST=1: every output is 0 and ALUOp is ALU_ADD. On the first edge after release, state is FETCH; counter, halt and trap are 0.
- Cycles per instruction with ihit/dhit in the request cycle:
  - J/JAL: 2.
  - Branch/JR: 3.
  - R-type/immediate: 4.
  - SW: 4.
  - LW: 5.
- Each wait cycle adds 1.
- A hit in the same cycle the counter reaches MEM_WAIT_MAX counts as success (hit wins).
- RST asserted mid-MEM drops dREN/dWEN in that same cycle; no write-back occurs.
- An ihit/dhit outside FETCH/MEM is ignored.

## Structure
- cpu_types_pkg gains:
  - mc_state_t enum.
  - pcsrc_t, regdst_t, memtoreg_t and extop_t encodings.
  - trap_t.
  - The HALT opcode constant if absent.
- Sub-module mc_instr_decode (combinational) maps opcode/funct to ALUOp, ExtOp, ALUSrc, RegDst, MemtoReg, instruction class and an illegal flag.
- The top module holds the FSM, wait counter and sticky flags.
- A matching interface, multicycle_control_unit_if, carries the ports with a cu modport.

## Test plan
- ADDU $3,$1,$2 with immediate ihit, after reset: IRWEN/PCWEN in cycle 0, DECODE cycle 1, ALUOp=ALU_ADD in EXEC cycle 2, RegWEN with RegDst=01 in cycle 3, FETCH in cycle 4.
- LW, dhit 3 cycles after MEM entry, MEM_WAIT_MAX=8: dREN held 4 cycles; then WB with MemtoReg=01; no trap.
- BEQ zero=1 then BNE zero=1: BEQ asserts PCWEN with PCSrc=01; BNE keeps PCWEN=0; both return to FETCH after 3 cycles.
- JAL: 2 cycles; RegWEN, RegDst=10, MemtoReg=10, PCSrc=10 in DECODE.
- MEM_WAIT_MAX=4 with ihit never asserted: trap=10 and halt=1 after 4 cycles; iREN=0 thereafter.
- Opcode 6'h3F: halt=1 with trap=00 after DECODE. Illegal funct: trap=01. RST mid-MEM SW: dWEN drops same cycle, FETCH next.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU encodings for the multicycle control unit
package cpu_types_pkg;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } mc_state_t;

    typedef enum logic [1:0] {PC_NEXT = 2'b00, PC_BRANCH = 2'b01, PC_JUMP = 2'b10, PC_REG = 2'b11} pcsrc_t;
    typedef enum logic [1:0] {RD_RT = 2'b00, RD_RD = 2'b01, RD_RA = 2'b10} regdst_t;
    typedef enum logic [1:0] {MR_ALU = 2'b00, MR_MEM = 2'b01, MR_PC4 = 2'b10} memtoreg_t;
    typedef enum logic [1:0] {EXT_ZERO = 2'b00, EXT_SIGN = 2'b01, EXT_LUI = 2'b10} extop_t;
    typedef enum logic [1:0] {TRAP_NONE = 2'b00, TRAP_ILLEGAL = 2'b01, TRAP_TIMEOUT = 2'b10} trap_t;

    typedef enum logic [3:0] {
        IC_RALU, IC_IALU, IC_BEQ, IC_BNE, IC_J, IC_JAL, IC_JR, IC_LW, IC_SW, IC_HALT
    } iclass_t;

    typedef struct packed {
        aluop_t    aluOp;
        extop_t    extOp;
        logic      aluSrc;
        regdst_t   regDst;
        memtoreg_t memtoReg;
        iclass_t   iclass;
        logic      illegal;
    } decode_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                           OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
                           OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E,
                           OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B, OP_HALT = 6'h3F;

    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR = 6'h08, FN_ADD = 6'h20,
                           FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23, FN_AND = 6'h24,
                           FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2A,
                           FN_SLTU = 6'h2B;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - bundled control unit ports with a cu modport
interface multicycle_control_unit_if
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input logic CLK
);
    logic              RST;
    logic [WORD_W-1:0] instr;
    logic              ihit;
    logic              dhit;
    logic              zero;
    logic              iREN;
    logic              dREN;
    logic              dWEN;
    logic              IRWEN;
    logic              PCWEN;
    logic [1:0]        PCSrc;
    logic [1:0]        RegDst;
    logic [1:0]        MemtoReg;
    logic              ALUSrc;
    logic [1:0]        ExtOp;
    aluop_t            ALUOp;
    logic              RegWEN;
    logic              halt;
    logic [1:0]        trap;

    modport cu (
        input  CLK, RST, instr, ihit, dhit, zero,
        output iREN, dREN, dWEN, IRWEN, PCWEN, PCSrc, RegDst, MemtoReg,
               ALUSrc, ExtOp, ALUOp, RegWEN, halt, trap
    );
endinterface

// File: rtl/mc_instr_decode.sv
// rtl/mc_instr_decode.sv - combinational opcode/funct decode for the multicycle control unit
module mc_instr_decode
    import cpu_types_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output decode_t    dec
);
    always_comb begin
        dec          = '0;
        dec.aluOp    = ALU_ADD;
        dec.extOp    = EXT_SIGN;
        dec.aluSrc   = 1'b1;
        dec.regDst   = RD_RT;
        dec.memtoReg = MR_ALU;
        dec.iclass   = IC_IALU;
        dec.illegal  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dec.aluSrc = 1'b0;
                dec.extOp  = EXT_ZERO;
                dec.regDst = RD_RD;
                dec.iclass = IC_RALU;
                case (funct)
                    FN_SLL:          dec.aluOp = ALU_SLL;
                    FN_SRL:          dec.aluOp = ALU_SRL;
                    FN_ADD, FN_ADDU: dec.aluOp = ALU_ADD;
                    FN_SUB, FN_SUBU: dec.aluOp = ALU_SUB;
                    FN_AND:          dec.aluOp = ALU_AND;
                    FN_OR:           dec.aluOp = ALU_OR;
                    FN_XOR:          dec.aluOp = ALU_XOR;
                    FN_NOR:          dec.aluOp = ALU_NOR;
                    FN_SLT:          dec.aluOp = ALU_SLT;
                    FN_SLTU:         dec.aluOp = ALU_SLTU;
                    FN_JR:           dec.iclass = IC_JR;
                    default:         dec.illegal = 1'b1;
                endcase
            end
            OP_J:     begin dec.iclass = IC_J; dec.aluSrc = 1'b0; end
            OP_JAL:   begin
                dec.iclass   = IC_JAL;
                dec.aluSrc   = 1'b0;
                dec.regDst   = RD_RA;
                dec.memtoReg = MR_PC4;
            end
            OP_BEQ:   begin dec.iclass = IC_BEQ; dec.aluOp = ALU_SUB; dec.aluSrc = 1'b0; end
            OP_BNE:   begin dec.iclass = IC_BNE; dec.aluOp = ALU_SUB; dec.aluSrc = 1'b0; end
            OP_ADDI, OP_ADDIU: dec.aluOp = ALU_ADD;
            OP_SLTI:  dec.aluOp = ALU_SLT;
            OP_SLTIU: dec.aluOp = ALU_SLTU;
            OP_ANDI:  begin dec.aluOp = ALU_AND; dec.extOp = EXT_ZERO; end
            OP_ORI:   begin dec.aluOp = ALU_OR;  dec.extOp = EXT_ZERO; end
            OP_XORI:  begin dec.aluOp = ALU_XOR; dec.extOp = EXT_ZERO; end
            OP_LUI:   begin dec.aluOp = ALU_OR;  dec.extOp = EXT_LUI;  end
            OP_LW:    begin dec.iclass = IC_LW; dec.memtoReg = MR_MEM; end
            OP_SW:    dec.iclass = IC_SW;
            OP_HALT:  begin dec.iclass = IC_HALT; dec.aluSrc = 1'b0; end
            default:  dec.illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - FETCH/DECODE/EXEC/MEM/WB sequencer with sticky halt, trap and memory-wait timeout
module multicycle_control_unit
    import cpu_types_pkg::*;
#(
    parameter int WORD_W       = 32,
    parameter int MEM_WAIT_MAX = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WORD_W-1:0] instr,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              zero,
    output logic              iREN,
    output logic              dREN,
    output logic              dWEN,
    output logic              IRWEN,
    output logic              PCWEN,
    output logic [1:0]        PCSrc,
    output logic [1:0]        RegDst,
    output logic [1:0]        MemtoReg,
    output logic              ALUSrc,
    output logic [1:0]        ExtOp,
    output aluop_t            ALUOp,
    output logic              RegWEN,
    output logic              halt,
    output logic [1:0]        trap
);
    localparam int CNT_W = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_WAIT_MAX);

    mc_state_t        state, nextState;
    trap_t            trapQ, trapNext;
    logic             haltQ;
    logic [CNT_W-1:0] waitCnt;
    decode_t          dec;
    logic             waiting, memHit, timedOut;
    logic             unusedFields;

    assign unusedFields = ^instr[WORD_W-7:6];

    mc_instr_decode u_decode (
        .opcode (instr[WORD_W-1:WORD_W-6]),
        .funct  (instr[5:0]),
        .dec    (dec)
    );

    // A hit arriving on the cycle the counter reaches the limit still completes the access.
    always_comb begin
        waiting  = (state == S_FETCH) || (state == S_MEM);
        memHit   = (state == S_FETCH) ? ihit : dhit;
        timedOut = waiting && (MEM_WAIT_MAX != 0) && (waitCnt == CNT_MAX) && !memHit;
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= S_FETCH;
        else     state <= nextState;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            waitCnt <= '0;
            haltQ   <= 1'b0;
            trapQ   <= TRAP_NONE;
        end else begin
            if ((nextState != state) || (waiting && memHit)) waitCnt <= '0;
            else if (waiting && (MEM_WAIT_MAX != 0))          waitCnt <= waitCnt + 1'b1;
            if (nextState == S_HALT)    haltQ <= 1'b1;
            if (trapNext != TRAP_NONE)  trapQ <= trapNext;
        end
    end

    always_comb begin
        nextState = state;
        trapNext  = TRAP_NONE;
        case (state)
            S_FETCH: begin
                if (timedOut) begin
                    nextState = S_HALT;
                    trapNext  = TRAP_TIMEOUT;
                end else if (ihit) begin
                    nextState = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec.illegal) begin
                    nextState = S_HALT;
                    trapNext  = TRAP_ILLEGAL;
                end else begin
                    case (dec.iclass)
                        IC_HALT:     nextState = S_HALT;
                        IC_J, IC_JAL: nextState = S_FETCH;
                        default:     nextState = S_EXEC;
                    endcase
                end
            end
            S_EXEC: begin
                case (dec.iclass)
                    IC_BEQ, IC_BNE, IC_JR: nextState = S_FETCH;
                    IC_LW, IC_SW:          nextState = S_MEM;
                    default:               nextState = S_WB;
                endcase
            end
            S_MEM: begin
                if (timedOut) begin
                    nextState = S_HALT;
                    trapNext  = TRAP_TIMEOUT;
                end else if (dhit) begin
                    nextState = (dec.iclass == IC_LW) ? S_WB : S_FETCH;
                end
            end
            S_WB:    nextState = S_FETCH;
            S_HALT:  nextState = S_HALT;
            default: nextState = S_FETCH;
        endcase
    end

    // Reset gates every output so requests drop in the very cycle RST rises.
    always_comb begin
        iREN     = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        IRWEN    = 1'b0;
        PCWEN    = 1'b0;
        RegWEN   = 1'b0;
        PCSrc    = PC_NEXT;
        RegDst   = RD_RT;
        MemtoReg = MR_ALU;
        ALUSrc   = 1'b0;
        ExtOp    = EXT_ZERO;
        ALUOp    = ALU_ADD;
        halt     = haltQ && !RST;
        trap     = RST ? TRAP_NONE : trapQ;
        if (!RST) begin
            case (state)
                S_FETCH: begin
                    iREN = !timedOut;
                    if (ihit) begin
                        IRWEN = 1'b1;
                        PCWEN = 1'b1;
                        PCSrc = PC_NEXT;
                    end
                end
                S_DECODE: begin
                    if (!dec.illegal && (dec.iclass == IC_J || dec.iclass == IC_JAL)) begin
                        PCWEN = 1'b1;
                        PCSrc = PC_JUMP;
                    end
                    if (!dec.illegal && dec.iclass == IC_JAL) begin
                        RegWEN   = 1'b1;
                        RegDst   = RD_RA;
                        MemtoReg = MR_PC4;
                    end
                end
                S_EXEC: begin
                    ALUOp  = dec.aluOp;
                    ALUSrc = dec.aluSrc;
                    ExtOp  = dec.extOp;
                    case (dec.iclass)
                        IC_BEQ:  begin PCWEN = zero;  PCSrc = PC_BRANCH; end
                        IC_BNE:  begin PCWEN = !zero; PCSrc = PC_BRANCH; end
                        IC_JR:   begin PCWEN = 1'b1;  PCSrc = PC_REG;    end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    dREN = (dec.iclass == IC_LW) && !timedOut;
                    dWEN = (dec.iclass == IC_SW) && !timedOut;
                end
                S_WB: begin
                    RegWEN   = 1'b1;
                    RegDst   = dec.regDst;
                    MemtoReg = dec.memtoReg;
                end
                default: ;
            endcase
        end
    end
endmodule
